l2_arbiter: RTL and testbench

- Shares the single L2 memory port between the instruction-side and data-side L1 caches.
- Each L1 cache controller issues cacheline read/write requests (fetch_cline / write_back) and holds them until it sees its response.
- The arbiter picks one requester, registers its address and write data onto the L2 port, and routes l2_resp and l2_rdata back to that requester only.
- It sits between the two L1 cache control/datapath pairs and the L2 cache.

---
 rtl/l2_arbiter_if.sv | 35 +++
 rtl/l2_arbiter.sv | 117 +++++++++++
 tb/tb_l2_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 memory-port signals around l2_arbiter.
// The master modport is the arbiter's view; slave is the view of the caches and L2.
interface l2_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
        output i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_address, l2_wdata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
        input  i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_address, l2_wdata
    );
endinterface

// File: rtl/l2_arbiter.sv
// Shares the L2 memory port between the I-cache and D-cache; one transaction at a time.
// Define L2_ARB_ROUND_ROBIN_EN to alternate on ties; default build gives D fixed priority.
module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic           clk,
    input  logic           reset_n,
    l2_arbiter_if.master   bus,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              i_req;
    logic              d_req;
    logic              d_wins;
    logic              i_resp;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;

    // A simultaneous read and write from the D side is malformed and ignored
    assign i_req = bus.i_read;
    assign d_req = bus.d_read ^ bus.d_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
    assign d_wins = !i_req || (last_grant == GNT_I);
`else
    assign d_wins = 1'b1;
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req && d_wins) begin
                    state_nxt = GRANT_D;
                end else if (i_req) begin
                    state_nxt = GRANT_I;
                end
            end
            GRANT_I: begin
                if (bus.l2_resp) begin
                    i_resp    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GRANT_D: begin
                if (bus.l2_resp) begin
                    d_resp    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // L2 port registers: loaded on the grant edge, held through the grant,
    // strobes cleared on the edge that consumes l2_resp
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
            l2_address <= '0;
            l2_wdata   <= '0;
            last_grant <= GNT_I;
        end else begin
            if (state == IDLE && state_nxt == GRANT_D) begin
                l2_read    <= bus.d_read;
                l2_write   <= bus.d_write;
                l2_address <= bus.d_address;
                l2_wdata   <= bus.d_wdata;
            end else if (state == IDLE && state_nxt == GRANT_I) begin
                l2_read    <= 1'b1;
                l2_write   <= 1'b0;
                l2_address <= bus.i_address;
                l2_wdata   <= '0;
            end else if (state != IDLE && state_nxt == IDLE) begin
                l2_read    <= 1'b0;
                l2_write   <= 1'b0;
                last_grant <= (state == GRANT_D) ? GNT_D : GNT_I;
            end
        end
    end

    assign bus.l2_read    = l2_read;
    assign bus.l2_write   = l2_write;
    assign bus.l2_address = l2_address;
    assign bus.l2_wdata   = l2_wdata;
    assign bus.i_resp     = i_resp;
    assign bus.d_resp     = d_resp;
    assign bus.i_rdata    = bus.l2_rdata;
    assign bus.d_rdata    = bus.l2_rdata;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter; honours L2_ARB_ROUND_ROBIN_EN for the tie sequence.
module tb_l2_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic clk;
    logic reset_n;
    logic busy;
    int   total;
    int   bad;

    l2_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [LINE_W-1:0] data_a5;
    logic [LINE_W-1:0] data_11;
    logic [LINE_W-1:0] data_3c;
    logic [ADDR_W-1:0] tie_addr [3];

    initial begin
        total   = 0;
        bad     = 0;
        data_a5 = {16{8'hA5}};
        data_11 = {16{8'h11}};
        data_3c = {16{8'h3C}};
`ifdef L2_ARB_ROUND_ROBIN_EN
        tie_addr[0] = 16'h8000;
        tie_addr[1] = 16'h0100;
        tie_addr[2] = 16'h8000;
`else
        tie_addr[0] = 16'h8000;
        tie_addr[1] = 16'h8000;
        tie_addr[2] = 16'h8000;
`endif

        reset_n       = 1'b0;
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        bus.l2_rdata  = '0;
        bus.l2_resp   = 1'b1;

        // Reset state, with a stray l2_resp present
        #1;
        chk1("rst_l2_read", bus.l2_read, 1'b0);
        chk1("rst_l2_write", bus.l2_write, 1'b0);
        chk16("rst_l2_address", bus.l2_address, 16'h0000);
        chk128("rst_l2_wdata", bus.l2_wdata, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_i_resp", bus.i_resp, 1'b0);
        chk1("rst_d_resp", bus.d_resp, 1'b0);
        step();
        step();
        reset_n     = 1'b1;
        bus.l2_resp = 1'b0;
        step();

        // Lone I-cache fetch at 0x1230, L2 answers three cycles after l2_read rises
        bus.i_read    = 1'b1;
        bus.i_address = 16'h1230;
        step();
        chk1("i_l2_read", bus.l2_read, 1'b1);
        chk1("i_l2_write", bus.l2_write, 1'b0);
        chk16("i_l2_address", bus.l2_address, 16'h1230);
        chk1("i_busy", busy, 1'b1);
        chk1("i_resp_early", bus.i_resp, 1'b0);
        step();
        step();
        chk1("i_l2_read_held", bus.l2_read, 1'b1);
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = data_a5;
        #1;
        chk1("i_resp", bus.i_resp, 1'b1);
        chk128("i_rdata", bus.i_rdata, data_a5);
        chk1("i_d_resp", bus.d_resp, 1'b0);
        step();
        chk1("i_busy_after", busy, 1'b0);
        chk1("i_l2_read_after", bus.l2_read, 1'b0);
        chk1("idle_resp_ignored", bus.i_resp, 1'b0);
        bus.l2_resp = 1'b0;
        bus.i_read  = 1'b0;
        step();

        // Lone D-cache write-back at 0x4000
        bus.d_write   = 1'b1;
        bus.d_address = 16'h4000;
        bus.d_wdata   = data_11;
        step();
        chk1("dw_l2_write", bus.l2_write, 1'b1);
        chk1("dw_l2_read", bus.l2_read, 1'b0);
        chk16("dw_l2_address", bus.l2_address, 16'h4000);
        chk128("dw_l2_wdata", bus.l2_wdata, data_11);
        step();
        chk1("dw_d_resp_early", bus.d_resp, 1'b0);
        bus.l2_resp = 1'b1;
        #1;
        chk1("dw_d_resp", bus.d_resp, 1'b1);
        chk1("dw_i_resp", bus.i_resp, 1'b0);
        chk1("dw_l2_read_resp", bus.l2_read, 1'b0);
        step();
        chk1("dw_d_resp_pulse", bus.d_resp, 1'b0);
        chk1("dw_l2_write_after", bus.l2_write, 1'b0);
        bus.l2_resp = 1'b0;
        bus.d_write = 1'b0;
        step();

        // Fresh reset so the tie sequence starts from last_grant = I
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Simultaneous requests held across three transactions
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0100;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h8000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk16($sformatf("tie%0d_l2_address", k), bus.l2_address, tie_addr[k]);
            chk1($sformatf("tie%0d_l2_read", k), bus.l2_read, 1'b1);
            bus.l2_resp  = 1'b1;
            bus.l2_rdata = data_3c;
            #1;
            chk1($sformatf("tie%0d_d_resp", k), bus.d_resp, tie_addr[k] == 16'h8000);
            chk1($sformatf("tie%0d_i_resp", k), bus.i_resp, tie_addr[k] == 16'h0100);
            step();
            chk1($sformatf("tie%0d_gap_busy", k), busy, 1'b0);
            bus.l2_resp = 1'b0;
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        step();

        // d_read and d_write together is not a request
        bus.d_read    = 1'b1;
        bus.d_write   = 1'b1;
        bus.d_address = 16'h5555;
        step();
        step();
        chk1("both_l2_read", bus.l2_read, 1'b0);
        chk1("both_l2_write", bus.l2_write, 1'b0);
        chk1("both_busy", busy, 1'b0);
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        step();

        // Write-back immediately followed by a fetch from the D side
        bus.d_write   = 1'b1;
        bus.d_address = 16'h2000;
        bus.d_wdata   = data_a5;
        step();
        chk1("wbf_l2_write", bus.l2_write, 1'b1);
        chk16("wbf_wb_address", bus.l2_address, 16'h2000);
        bus.l2_resp = 1'b1;
        #1;
        chk1("wbf_wb_d_resp", bus.d_resp, 1'b1);
        step();
        bus.l2_resp   = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h2040;
        #1;
        chk1("wbf_gap_l2_write", bus.l2_write, 1'b0);
        chk1("wbf_gap_l2_read", bus.l2_read, 1'b0);
        chk1("wbf_gap_busy", busy, 1'b0);
        step();
        chk1("wbf_fetch_l2_read", bus.l2_read, 1'b1);
        chk1("wbf_fetch_l2_write", bus.l2_write, 1'b0);
        chk16("wbf_fetch_address", bus.l2_address, 16'h2040);
        bus.l2_resp = 1'b1;
        #1;
        chk1("wbf_fetch_d_resp", bus.d_resp, 1'b1);
        step();
        bus.l2_resp = 1'b0;
        bus.d_read  = 1'b0;
        step();

        // Asynchronous reset in the middle of an I grant, then a late l2_resp
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0300;
        step();
        chk1("rmid_l2_read", bus.l2_read, 1'b1);
        chk1("rmid_busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("rmid_async_l2_read", bus.l2_read, 1'b0);
        chk1("rmid_async_busy", busy, 1'b0);
        chk16("rmid_async_address", bus.l2_address, 16'h0000);
        bus.i_read = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        bus.l2_resp = 1'b1;
        #1;
        chk1("rmid_late_i_resp", bus.i_resp, 1'b0);
        chk1("rmid_late_d_resp", bus.d_resp, 1'b0);
        step();
        chk1("rmid_late_busy", busy, 1'b0);
        chk1("rmid_late_l2_read", bus.l2_read, 1'b0);
        bus.l2_resp = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
